// File: rtl/interrupt_controller.sv
// Seven-level prioritised interrupt controller with per-source synchronisers,
// a level/edge enable mask, a pending status register and an IACK handshake FSM.
module interrupt_controller #(
  parameter int         SYNC_STAGES = 2,          // at least 2
  parameter logic [6:0] EDGE_MASK   = 7'b0000000
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic [6:0] irq_n,
  input  logic       as,
  input  logic [2:0] fc,
  input  logic [3:0] addr_space,
  input  logic [2:0] iack_level,
  input  logic       reg_cs,
  input  logic       reg_sel,
  input  logic       write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [2:0] n_ipl,
  output logic       n_avec,
  output logic       spurious
);

  typedef enum logic [1:0] {IDLE, ACK, WAIT_END} state_t;

  state_t                        state_reg, state_next;
  logic [SYNC_STAGES-1:0][6:0]   sync_reg;
  logic [6:0]                    irq_s;
  logic [6:0]                    mask_reg;
  logic [6:0]                    pending;
  logic [7:0]                    pending_ext;
  logic [2:0]                    level_top;
  logic [2:0]                    n_ipl_reg;
  logic [2:0]                    ack_level_reg;
  logic                          iack_dec;
  logic                          ack_take;
  logic                          ack_hit;
  logic                          mask_wr;
  logic                          busy;
  logic                          unused_bit;

  assign unused_bit = data_in[0];

  // Raw pins only ever reach the first synchroniser stage.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) sync_reg <= '1;
    else          sync_reg <= {sync_reg[SYNC_STAGES-2:0], irq_n};
  end

  assign irq_s = sync_reg[SYNC_STAGES-1];

  assign mask_wr     = reg_cs & write & ~reg_sel;
  assign iack_dec    = as && (fc == 3'b111) && (addr_space == 4'hF);
  assign ack_take    = (state_reg == IDLE) && iack_dec;
  assign pending_ext = {pending, 1'b0};
  // Level 0 indexes the constant zero bit, so it always resolves as spurious.
  assign ack_hit     = ack_take && pending_ext[iack_level];

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset)     mask_reg <= 7'h00;
    else if (mask_wr) mask_reg <= data_in[7:1];
  end

  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_src
      if (EDGE_MASK[gi]) begin : g_edge
        logic prev_reg;
        logic latch_reg;
        logic edge_set;
        logic edge_clr;

        assign edge_set = prev_reg & ~irq_s[gi] & mask_reg[gi];
        assign edge_clr = (ack_hit && (iack_level == 3'(gi + 1))) ||
                          (mask_wr && !data_in[gi + 1]);

        // Set has priority so an edge coinciding with its acknowledge is kept.
        always_ff @(posedge clock or negedge n_reset) begin
          if (!n_reset) begin
            prev_reg  <= 1'b1;
            latch_reg <= 1'b0;
          end else begin
            prev_reg <= irq_s[gi];
            if (edge_set)      latch_reg <= 1'b1;
            else if (edge_clr) latch_reg <= 1'b0;
          end
        end

        assign pending[gi] = latch_reg;
      end else begin : g_level
        assign pending[gi] = ~irq_s[gi] & mask_reg[gi];
      end
    end
  endgenerate

  always_comb begin
    level_top = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (pending[i]) level_top = 3'(i + 1);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (iack_dec) state_next = ACK;
      ACK:      state_next = WAIT_END;
      WAIT_END: if (!as) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_reg     <= IDLE;
      ack_level_reg <= 3'd0;
      n_ipl_reg     <= 3'b111;
    end else begin
      state_reg <= state_next;
      // Holds the acknowledged level, or zero when the acknowledge is spurious.
      if (ack_take) ack_level_reg <= ack_hit ? iack_level : 3'd0;
      if (state_reg == IDLE) n_ipl_reg <= ~level_top;
    end
  end

  assign busy     = (state_reg != IDLE);
  assign n_avec   = ~(busy && (ack_level_reg != 3'd0));
  assign spurious = busy && (ack_level_reg == 3'd0);
  assign n_ipl    = n_ipl_reg;

  always_comb begin
    data_out = 8'h00;
    if (reg_cs) data_out = reg_sel ? {pending, 1'b0} : {mask_reg, 1'b0};
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench: stimulus pushes cycle-stamped expectations derived from a
// behavioural model; a negedge monitor pops and compares them against the DUT.
module tb_interrupt_controller;

  localparam int         SYNC  = 2;
  localparam logic [6:0] EDGES = 7'b0000100;

  logic       clock = 1'b0;
  logic       n_reset;
  logic [6:0] irq_n;
  logic       as;
  logic [2:0] fc;
  logic [3:0] addr_space;
  logic [2:0] iack_level;
  logic       reg_cs;
  logic       reg_sel;
  logic       write;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [2:0] n_ipl;
  logic       n_avec;
  logic       spurious;

  interrupt_controller #(.SYNC_STAGES(SYNC), .EDGE_MASK(EDGES)) dut (
    .clock(clock), .n_reset(n_reset), .irq_n(irq_n), .as(as), .fc(fc),
    .addr_space(addr_space), .iack_level(iack_level), .reg_cs(reg_cs),
    .reg_sel(reg_sel), .write(write), .data_in(data_in), .data_out(data_out),
    .n_ipl(n_ipl), .n_avec(n_avec), .spurious(spurious)
  );

  always #5 clock = ~clock;

  typedef struct {
    int    cyc;
    string name;
    int    field;   // 0 n_ipl, 1 n_avec, 2 spurious, 3 data_out
    int    val;
  } exp_t;

  exp_t       sb_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [6:0] m_mask;
  logic [6:0] m_edge;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin : monitor
    int k;
    int act;
    k = 0;
    while (k < sb_q.size()) begin
      if (sb_q[k].cyc <= cyc) begin
        case (sb_q[k].field)
          0:       act = int'(n_ipl);
          1:       act = int'(n_avec);
          2:       act = int'(spurious);
          default: act = int'(data_out);
        endcase
        checks++;
        if (sb_q[k].cyc != cyc || act != sb_q[k].val) begin
          failures++;
          $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h",
                   sb_q[k].name, cyc, act, sb_q[k].val);
        end
        sb_q.delete(k);
      end else begin
        k++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1);
  end

  // Reference model: pending set from the settled pins, mask and edge flags.
  function automatic logic [6:0] m_pending();
    logic [6:0] p;
    for (int n = 0; n < 7; n++)
      p[n] = EDGES[n] ? m_edge[n] : (~irq_n[n] & m_mask[n]);
    return p;
  endfunction

  function automatic int m_level();
    logic [6:0] p;
    p = m_pending();
    for (int n = 6; n >= 0; n--)
      if (p[n]) return n + 1;
    return 0;
  endfunction

  task automatic expect_at(input int dc, input string name, input int field, input int val);
    exp_t e;
    e.cyc = cyc + dc; e.name = name; e.field = field; e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic mask_write(input logic [7:0] d, input logic sel);
    reg_cs = 1'b1; reg_sel = sel; data_in = d; write = 1'b1;
    tick(1);
    write = 1'b0; reg_sel = 1'b0;
    if (!sel) begin
      m_mask = d[7:1];
      m_edge = m_edge & d[7:1];
    end
    $display("txn mask_write data=0x%02h sel=%0d cycle=%0d", d, sel, cyc);
  endtask

  task automatic pulse3();
    irq_n[2] = 1'b0;
    tick(1);
    irq_n[2] = 1'b1;
    if (m_mask[2]) m_edge[2] = 1'b1;
  endtask

  task automatic iack(input int lvl, input int hold, input bit keep);
    int         pre;
    bit         hit;
    logic [6:0] p;
    pre = 7 - m_level();
    p   = m_pending();
    hit = (lvl > 0) && p[lvl-1];
    as = 1'b1; fc = 3'b111; addr_space = 4'hF; iack_level = 3'(lvl);
    expect_at(0, "avec_before_ack", 1, 1);
    tick(1);
    if (hit && !keep) m_edge[lvl-1] = 1'b0;
    repeat (hold) begin
      expect_at(0, "avec_in_ack", 1, hit ? 0 : 1);
      expect_at(0, "spurious_in_ack", 2, hit ? 0 : 1);
      expect_at(0, "ipl_frozen", 0, pre);
      tick(1);
    end
    as = 1'b0;
    expect_at(0, "avec_as_low", 1, hit ? 0 : 1);
    expect_at(0, "spurious_as_low", 2, hit ? 0 : 1);
    tick(1);
    fc = 3'b000; addr_space = 4'h0; iack_level = 3'd0;
    expect_at(0, "avec_idle", 1, 1);
    expect_at(0, "spurious_idle", 2, 0);
    expect_at(0, "ipl_held_idle", 0, pre);
    expect_at(1, "ipl_resume", 0, 7 - m_level());
    $display("txn iack level=%0d hit=%0d cycle=%0d", lvl, hit, cyc);
  endtask

  initial begin
    n_reset = 1'b0; irq_n = 7'h7F; as = 1'b0; fc = 3'b000; addr_space = 4'h0;
    iack_level = 3'd0; reg_cs = 1'b1; reg_sel = 1'b0; write = 1'b0; data_in = 8'h00;
    m_mask = 7'h00; m_edge = 7'h00;

    tick(1);
    expect_at(0, "rst_ipl", 0, 7);
    expect_at(0, "rst_avec", 1, 1);
    expect_at(0, "rst_spurious", 2, 0);
    expect_at(0, "rst_mask", 3, 8'h00);
    tick(2);
    n_reset = 1'b1;
    tick(1);

    // Level 5, level triggered: SYNC+1 clocks in each direction.
    mask_write(8'hFE, 1'b0);
    irq_n[4] = 1'b0;
    expect_at(SYNC, "l5_assert_early", 0, 7);
    expect_at(SYNC + 1, "l5_assert", 0, 3'b010);
    tick(4);
    irq_n[4] = 1'b1;
    expect_at(SYNC, "l5_release_early", 0, 3'b010);
    expect_at(SYNC + 1, "l5_release", 0, 7);
    tick(4);
    reg_cs = 1'b0;
    expect_at(0, "read_no_cs", 3, 8'h00);
    tick(1);
    reg_cs = 1'b1;
    expect_at(0, "read_mask_fe", 3, 8'hFE);
    tick(1);

    // Levels 2 and 6 together, then level 6 masked off.
    irq_n[1] = 1'b0; irq_n[5] = 1'b0;
    tick(4);
    reg_sel = 1'b1;
    expect_at(0, "l2l6_ipl", 0, 3'b001);
    expect_at(0, "l2l6_pending", 3, 8'h44);
    tick(1);
    mask_write(8'hBE, 1'b0);
    expect_at(0, "mask_be_early", 0, 3'b001);
    expect_at(1, "mask_be_ipl", 0, 3'b101);
    tick(2);
    irq_n = 7'h7F;
    tick(4);
    expect_at(0, "l2l6_cleared", 0, 7);

    // Level 3 edge: one synchronised low cycle sets the latch.
    pulse3();
    reg_sel = 1'b1;
    expect_at(1, "edge3_pend_early", 3, 8'h00);
    expect_at(2, "edge3_pend", 3, 8'h08);
    expect_at(2, "edge3_ipl_early", 0, 7);
    expect_at(3, "edge3_ipl", 0, 3'b100);
    tick(4);
    reg_sel = 1'b0;
    iack(3, 3, 1'b0);
    reg_sel = 1'b1;
    expect_at(0, "edge3_acked_pend", 3, 8'h00);
    tick(2);
    reg_sel = 1'b0;

    // Spurious acknowledge with nothing pending.
    iack(4, 3, 1'b0);
    tick(1);

    // New edge lands on the acknowledge-clear edge: the latch survives.
    pulse3();
    tick(4);
    pulse3();
    tick(1);
    iack(3, 2, 1'b1);
    reg_sel = 1'b1;
    expect_at(0, "edge3_survives", 3, 8'h08);
    tick(2);
    reg_sel = 1'b0;
    iack(3, 2, 1'b0);
    tick(2);

    // Reset asserted in WAIT_END releases outputs without a clock edge.
    mask_write(8'hFE, 1'b0);
    irq_n[4] = 1'b0;
    tick(4);
    expect_at(0, "pre_rst_ipl", 0, 3'b010);
    as = 1'b1; fc = 3'b111; addr_space = 4'hF; iack_level = 3'd5;
    tick(1);
    expect_at(0, "pre_rst_avec", 1, 0);
    tick(1);
    #2;
    n_reset = 1'b0;
    #1;
    expect_at(0, "mid_rst_avec", 1, 1);
    expect_at(0, "mid_rst_spurious", 2, 0);
    expect_at(0, "mid_rst_ipl", 0, 7);
    as = 1'b0; fc = 3'b000; addr_space = 4'h0; iack_level = 3'd0; irq_n = 7'h7F;
    m_mask = 7'h00; m_edge = 7'h00;
    tick(1);
    n_reset = 1'b1;
    reg_cs = 1'b1; reg_sel = 1'b0;
    expect_at(0, "post_rst_mask", 3, 8'h00);
    expect_at(0, "post_rst_ipl", 0, 7);
    $display("txn reset_in_wait_end cycle=%0d", cyc);
    tick(2);

    // Randomised mask, pin and acknowledge traffic against the model.
    for (int it = 0; it < 30; it++) begin
      logic [7:0] d;
      logic       sel;
      d   = 8'($urandom);
      sel = ($urandom_range(0, 3) == 0);
      mask_write(d, sel);
      irq_n = 7'($urandom) | 7'h04;
      tick(4);
      reg_cs = 1'b1; reg_sel = 1'b1;
      expect_at(0, "rnd_ipl", 0, 7 - m_level());
      expect_at(0, "rnd_pending", 3, int'({m_pending(), 1'b0}));
      tick(1);
      reg_sel = 1'b0;
      expect_at(0, "rnd_mask", 3, int'({m_mask, 1'b0}));
      tick(1);
      if (it % 3 == 0) iack(int'($urandom_range(0, 7)), int'($urandom_range(1, 3)), 1'b0);
    end

    tick(2);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0 leftover entries", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
